// File: rtl/core_types_pkg.sv
// ============================================================================
// Module      : core_types_pkg
// Description : Shared core types: datapath width, fetch FSM states, PC mux
//               select encoding and redirect arbitration helper.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_types_pkg;

  localparam int N_BITS = 32;
  localparam logic [31:0] PC_RST_VAL = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    FETCH  = 2'd1,
    WAIT   = 2'd2,
    SQUASH = 2'd3
  } fetch_state_e;

  typedef enum logic [1:0] {
    PC_SEL_PLUS4  = 2'd0,
    PC_SEL_JAL    = 2'd1,
    PC_SEL_BRANCH = 2'd2,
    PC_SEL_JALR   = 2'd3
  } pc_sel_e;

  // Later pipeline stages win: jalr > branch > jal.
  function automatic pc_sel_e redirect_sel(input logic jal, input logic branch,
                                           input logic jalr);
    pc_sel_e sel;
    sel = PC_SEL_PLUS4;
    if (jalr)        sel = PC_SEL_JALR;
    else if (branch) sel = PC_SEL_BRANCH;
    else if (jal)    sel = PC_SEL_JAL;
    return sel;
  endfunction

endpackage

`default_nettype wire

// File: rtl/fetch_inst_buf.sv
// ============================================================================
// Module      : fetch_inst_buf
// Description : 2-entry {inst, pc} queue toward decode; entry 0 is the head so
//               all outputs come straight from flops.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_inst_buf #(
  parameter int N_BITS = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              push,
  input  logic [N_BITS-1:0] push_inst,
  input  logic [N_BITS-1:0] push_pc,
  input  logic              pop,
  input  logic              flush,
  output logic              head_valid,
  output logic [N_BITS-1:0] head_inst,
  output logic [N_BITS-1:0] head_pc,
  output logic [1:0]        count
);

  logic [1:0]        r_vld;
  logic [N_BITS-1:0] r_inst0, r_inst1;
  logic [N_BITS-1:0] r_pc0, r_pc1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld   <= 2'b00;
      r_inst0 <= '0;
      r_inst1 <= '0;
      r_pc0   <= '0;
      r_pc1   <= '0;
    end else if (flush) begin
      r_vld <= 2'b00;
    end else begin
      case ({push, pop})
        2'b10: begin
          if (!r_vld[0]) begin
            r_inst0  <= push_inst;
            r_pc0    <= push_pc;
            r_vld[0] <= 1'b1;
          end else begin
            r_inst1  <= push_inst;
            r_pc1    <= push_pc;
            r_vld[1] <= 1'b1;
          end
        end
        2'b01: begin
          r_inst0 <= r_inst1;
          r_pc0   <= r_pc1;
          r_vld   <= {1'b0, r_vld[1]};
        end
        2'b11: begin
          // Occupancy is unchanged; only the contents advance.
          if (r_vld[1]) begin
            r_inst0 <= r_inst1;
            r_pc0   <= r_pc1;
            r_inst1 <= push_inst;
            r_pc1   <= push_pc;
          end else begin
            r_inst0 <= push_inst;
            r_pc0   <= push_pc;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_valid = r_vld[0];
  assign head_inst  = r_inst0;
  assign head_pc    = r_pc0;
  assign count      = {1'b0, r_vld[0]} + {1'b0, r_vld[1]};

endmodule

`default_nettype wire

// File: rtl/fetch_ctrl.sv
// ============================================================================
// Module      : fetch_ctrl
// Description : Fetch-stage sequencer: PC enable/select, single-outstanding
//               imem handshake, redirect squash and decode-facing queue.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fetch_ctrl
  import core_types_pkg::*;
#(
  parameter int N_BITS = core_types_pkg::N_BITS
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_BITS-1:0] pc,
  output logic [1:0]        pc_sel,
  output logic              pc_reg_en,
  input  logic              jal_valid,
  input  logic              branch_taken,
  input  logic              jalr_valid,
  input  logic              stall_in,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  input  logic              imem_rsp_valid,
  input  logic [N_BITS-1:0] imem_rsp_data,
  output logic              inst_valid,
  output logic [N_BITS-1:0] inst,
  output logic [N_BITS-1:0] inst_pc
);

  localparam logic [1:0] S_BOOT   = BOOT;
  localparam logic [1:0] S_FETCH  = FETCH;
  localparam logic [1:0] S_WAIT   = WAIT;
  localparam logic [1:0] S_SQUASH = SQUASH;

  logic [1:0]        r_state, w_state_nxt;
  logic [N_BITS-1:0] r_req_pc;
  logic              w_redirect, w_pop, w_push, w_flush, w_room, w_capture;
  logic [1:0]        w_count;
  pc_sel_e           w_redir_sel;

  assign w_redirect  = jal_valid | branch_taken | jalr_valid;
  assign w_redir_sel = redirect_sel(jal_valid, branch_taken, jalr_valid);
  assign w_pop       = inst_valid & ~stall_in;
  // A slot vacated by this cycle's pop counts as free.
  assign w_room      = (w_count < 2'd2) | w_pop;

  always_comb begin
    w_state_nxt    = r_state;
    imem_req_valid = 1'b0;
    pc_reg_en      = 1'b0;
    pc_sel         = PC_SEL_PLUS4;
    w_push         = 1'b0;
    w_flush        = 1'b0;
    w_capture      = 1'b0;
    case (r_state)
      S_BOOT: begin
        pc_reg_en   = rst_n;
        w_state_nxt = S_FETCH;
      end
      S_FETCH: begin
        if (w_redirect) begin
          pc_reg_en = 1'b1;
          pc_sel    = w_redir_sel;
          w_flush   = 1'b1;
        end else begin
          imem_req_valid = w_room;
          if (w_room && imem_req_ready) begin
            pc_reg_en   = 1'b1;
            w_capture   = 1'b1;
            w_state_nxt = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (w_redirect) begin
          pc_reg_en   = 1'b1;
          pc_sel      = w_redir_sel;
          w_flush     = 1'b1;
          w_state_nxt = imem_rsp_valid ? S_FETCH : S_SQUASH;
        end else if (imem_rsp_valid) begin
          w_push      = 1'b1;
          w_state_nxt = S_FETCH;
        end
      end
      S_SQUASH: begin
        if (w_redirect) begin
          pc_reg_en = 1'b1;
          pc_sel    = w_redir_sel;
          w_flush   = 1'b1;
        end
        // The stale response retires the squash even if a new redirect lands
        // in the same cycle; nothing else is outstanding to wait for.
        if (imem_rsp_valid) w_state_nxt = S_FETCH;
      end
      default: w_state_nxt = S_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_BOOT;
      r_req_pc <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_capture) r_req_pc <= pc;
    end
  end

  fetch_inst_buf #(
    .N_BITS(N_BITS)
  ) u_inst_buf (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (w_push),
    .push_inst (imem_rsp_data),
    .push_pc   (r_req_pc),
    .pop       (w_pop),
    .flush     (w_flush),
    .head_valid(inst_valid),
    .head_inst (inst),
    .head_pc   (inst_pc),
    .count     (w_count)
  );

endmodule

`default_nettype wire

// File: doc/fetch_ctrl.md
# fetch_ctrl

Sequencing controller for the fetch stage. It owns the PC register enable and the next-PC mux select, and runs the instruction-memory request/response handshake with at most one request outstanding. It prioritises redirects from decode and execute, squashes wrong-path responses, and buffers returned instructions in a 2-entry queue toward decode under downstream stall.

## Interface
Parameters:
- `N_BITS`, 32, address/instruction width (from `core_types_pkg`)

Ports:
- `clk`  in  1  core clock
- `rst_n`  in  1  reset, asynchronous, active-low
- `pc`  in  N_BITS  current PC register value
- `pc_sel`  out  2  next-PC mux select: 0 pc+4, 1 jal, 2 branch, 3 jalr
- `pc_reg_en`  out  1  PC register load enable
- `jal_valid`  in  1  decode-stage JAL redirect
- `branch_taken`  in  1  execute-stage taken-branch redirect
- `jalr_valid`  in  1  execute-stage JALR redirect
- `stall_in`  in  1  decode cannot accept an instruction this cycle
- `imem_req_valid`  out  1  fetch request valid; address is `pc`
- `imem_req_ready`  in  1  memory accepts the request
- `imem_rsp_valid`  in  1  response valid; single-cycle pulse, no backpressure
- `imem_rsp_data`  in  N_BITS  fetched instruction
- `inst_valid`  out  1  instruction presented to decode
- `inst`  out  N_BITS  instruction to decode
- `inst_pc`  out  N_BITS  PC of `inst`

## Operation
- **Redirect priority:** jalr > branch > jal. `redirect` = OR of all three.
- **PC reset value:** the PC register resets to 0xFFFFFFFC.
- **FSM states:** BOOT, FETCH, WAIT, SQUASH. Reset state is BOOT.
- **BOOT:**
  - Drives `pc_reg_en`=1, `pc_sel`=0, so PC becomes 0x0. Next state is FETCH.
  - `imem_req_valid`=0.
  - Redirect inputs are ignored.
- **FETCH:**
  - `imem_req_valid` = !redirect && (queue count < 2, counting entries leaving this cycle).
  - On a handshake: `pc_reg_en`=1, `pc_sel`=0, capture `pc` into `req_pc`, next state is WAIT.
  - With no handshake and no redirect, `pc_reg_en`=0.
- **WAIT:**
  - On `imem_rsp_valid`: push {`imem_rsp_data`, `req_pc`} into the queue, next state is FETCH.
  - Issue gating guarantees a free queue slot whenever a response arrives.
- **Redirect in FETCH or WAIT:**
  - `pc_reg_en`=1 and `pc_sel` = the winning source.
  - Queue is flushed, so `inst_valid`=0 from the next cycle.
  - From WAIT: a response in the same cycle is dropped and the next state is FETCH. Otherwise the next state is SQUASH.
  - From FETCH: state stays FETCH and no request is issued.
- **SQUASH:**
  - `imem_req_valid`=0.
  - The next `imem_rsp_valid` is discarded, then the next state is FETCH.
  - A further redirect updates PC and flushes the queue; state stays SQUASH.
- **Redirect vs stall:** a redirect overrides `stall_in` for the PC update and the flush.
- **Queue:**
  - Head drives `inst`/`inst_pc`; `inst_valid` = queue non-empty.
  - Pop when `inst_valid && !stall_in`.
  - Push and pop may occur in the same cycle.
  - Flush takes priority over push and pop.
- **Reset mid-operation:** returns to BOOT and clears the queue and `req_pc`. Any response already in flight is ignored because the block is in BOOT.

## Timing
- **Output reset values:** `pc_reg_en`=0 while `rst_n`=0; `pc_sel`=0; `imem_req_valid`=0; `inst_valid`=0; `inst`=0; `inst_pc`=0.
- **Registered vs combinational:**
  - Queue outputs are registered.
  - `pc_sel`, `pc_reg_en` and `imem_req_valid` are combinational from state and inputs.
- **Fetch latency:** request accepted in cycle N, earliest response N+1, `inst_valid` at N+2.
- **Redirect latency:** redirect in cycle N gives the new PC at N+1.
  - From FETCH, the request to the new PC is valid at N+1.
  - From WAIT, the request follows once the old response has been discarded.
- **Throughput:** one instruction per 2 cycles with a 1-cycle memory.
- **Queue full:** with 2 entries and `stall_in`=1, `imem_req_valid` stays 0 until a pop.

## Structure
- **`core_types_pkg` additions:**
  - `fetch_state_e` (BOOT, FETCH, WAIT, SQUASH)
  - `pc_sel_e` with PC_SEL_PLUS4=0, PC_SEL_JAL=1, PC_SEL_BRANCH=2, PC_SEL_JALR=3
  - `PC_RST_VAL`=32'hFFFFFFFC
- **Sub-module `fetch_inst_buf`:** 2-entry FIFO of {inst, pc} with push, pop, flush and count.
- **Top-level wiring:** `fetch_ctrl` instantiates `fetch_inst_buf`; the fetch-stage top wires `pc_sel`/`pc_reg_en` to its mux and PC register.

## Test plan
- **Reset/boot:** `rst_n` released, memory always ready, 1-cycle response → PC 0x0, 0x4, 0x8 requested; `inst_valid` with `inst_pc`=0x0 two cycles after the first handshake.
- **Stall fill:** `stall_in`=1 for 10 cycles → queue holds `inst_pc` 0x0 and 0x4, `imem_req_valid`=0; release → 0x0 then 0x4 consumed, then fetch resumes at 0x8.
- **Squash in WAIT:** branch_taken to 0x100 while in WAIT, response 2 cycles later → that response dropped, next `inst_pc`=0x100.
- **Priority:** jal_valid (0x40) and jalr_valid (0x80) in the same cycle → `pc_sel`=3, next `inst_pc`=0x80.
- **Redirect with response:** redirect in the same cycle as `imem_rsp_valid` → response dropped, state FETCH, no stale `inst_valid`.
- **Reset mid-flight:** `rst_n` asserted during WAIT → `inst_valid`=0 immediately, BOOT on release, a stray response ignored.
